// File: rtl/fp_addsub_pipe_if.sv
// ----------------------------------------------------------------------------
// fp_addsub_pipe_if
// Bundle between the FP execution unit and the pipelined single-precision
// adder/subtractor.
//   Operand side  : sa, sb, opcode, ma, mb, ea, eb
//   Debug side    : res, sss, mant (stage 1), out_mant, totalcarry (stage 2)
//   Result side   : sign, exponent, sum2 (stage 3)
// master = operand producer / result consumer, slave = the adder pipeline.
// ----------------------------------------------------------------------------
interface fp_addsub_pipe_if;
    logic        sa;
    logic        sb;
    logic        opcode;
    logic [22:0] ma;
    logic [22:0] mb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [7:0]  res;
    logic [23:0] sss;
    logic [23:0] mant;
    logic [23:0] out_mant;
    logic        totalcarry;
    logic        sign;
    logic [7:0]  exponent;
    logic [31:0] sum2;

    modport master (
        output sa, sb, opcode, ma, mb, ea, eb,
        input  res, sss, mant, out_mant, totalcarry, sign, exponent, sum2
    );

    modport slave (
        input  sa, sb, opcode, ma, mb, ea, eb,
        output res, sss, mant, out_mant, totalcarry, sign, exponent, sum2
    );
endinterface

// File: rtl/fp_addsub_pipe.sv
// ----------------------------------------------------------------------------
// fp_addsub_pipe
// Three-stage IEEE-754 single-precision adder/subtractor (align, add/sub,
// normalize). Truncating, denormals flushed to zero, no NaN handling;
// exponent overflow saturates to infinity, underflow flushes to +0.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears every pipeline register
//   bus  - fp_addsub_pipe_if.slave: operand fields in, debug and packed
//          result out (stage 1 after 1 cycle, stage 2 after 2, result after 3)
// ----------------------------------------------------------------------------
module fp_addsub_pipe (
    input  logic              clk,
    input  logic              rst,
    fp_addsub_pipe_if.slave   bus
);

    // Leading-zero count of a 24-bit significand (24 when the value is zero).
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (found) begin
                n = n;
            end else if (v[i]) begin
                found = 1'b1;
            end else begin
                n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // ---------------- stage 1 signals ----------------
    logic [23:0] sig_a_s;
    logic [23:0] sig_b_s;
    logic [23:0] small_s;
    logic        eff_sb_s;
    logic        a_big_s;
    logic [7:0]  res_d,  res_q;
    logic [23:0] sss_d,  sss_q;
    logic [23:0] mant_d, mant_q;
    logic [7:0]  exp1_d, exp1_q;
    logic        sign1_d, sign1_q;
    logic        sub1_d, sub1_q;

    // ---------------- stage 2 signals ----------------
    logic [24:0] sum25_s;
    logic [23:0] out_mant_d, out_mant_q;
    logic        totalcarry_d, totalcarry_q;
    logic [7:0]  exp2_d, exp2_q;
    logic        sign2_d, sign2_q;

    // ---------------- stage 3 signals ----------------
    logic [4:0]  lz_s;
    logic [23:0] norm_s;
    logic [8:0]  inc_exp_s;
    logic [7:0]  dec_exp_s;
    logic [22:0] frac_s;
    logic        sign_d, sign_q;
    logic [7:0]  exponent_d, exponent_q;
    logic [31:0] sum2_d, sum2_q;

    // Stage 1: operand prep, magnitude compare and alignment shift.
    always_comb begin
        sig_a_s  = 24'd0;
        sig_b_s  = 24'd0;
        small_s  = 24'd0;
        res_d    = 8'd0;
        sss_d    = 24'd0;
        mant_d   = 24'd0;
        exp1_d   = 8'd0;
        sign1_d  = 1'b0;
        eff_sb_s = bus.sb ^ bus.opcode;
        sub1_d   = bus.sa ^ eff_sb_s;

        // A zero exponent marks a zero operand; its fraction is ignored.
        if (bus.ea != 8'd0) begin
            sig_a_s = {1'b1, bus.ma};
        end else begin
            sig_a_s = 24'd0;
        end
        if (bus.eb != 8'd0) begin
            sig_b_s = {1'b1, bus.mb};
        end else begin
            sig_b_s = 24'd0;
        end

        // Ties (equal exponent and significand) pick A so a subtract never goes negative.
        a_big_s = (bus.ea > bus.eb) || ((bus.ea == bus.eb) && (sig_a_s >= sig_b_s));

        if (a_big_s) begin
            res_d   = bus.ea - bus.eb;
            sss_d   = sig_a_s;
            small_s = sig_b_s;
            exp1_d  = bus.ea;
            sign1_d = bus.sa;
        end else begin
            res_d   = bus.eb - bus.ea;
            sss_d   = sig_b_s;
            small_s = sig_a_s;
            exp1_d  = bus.eb;
            sign1_d = eff_sb_s;
        end

        if (res_d >= 8'd24) begin
            mant_d = 24'd0;
        end else begin
            mant_d = small_s >> res_d;
        end
    end

    // Stage 1 pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= 8'd0;
            sss_q   <= 24'd0;
            mant_q  <= 24'd0;
            exp1_q  <= 8'd0;
            sign1_q <= 1'b0;
            sub1_q  <= 1'b0;
        end else begin
            res_q   <= res_d;
            sss_q   <= sss_d;
            mant_q  <= mant_d;
            exp1_q  <= exp1_d;
            sign1_q <= sign1_d;
            sub1_q  <= sub1_d;
        end
    end

    // Stage 2: significand add or subtract (larger minus smaller).
    always_comb begin
        sum25_s      = {1'b0, sss_q} + {1'b0, mant_q};
        out_mant_d   = 24'd0;
        totalcarry_d = 1'b0;
        exp2_d       = exp1_q;
        sign2_d      = sign1_q;
        if (sub1_q) begin
            out_mant_d   = sss_q - mant_q;
            totalcarry_d = 1'b0;
        end else begin
            out_mant_d   = sum25_s[23:0];
            totalcarry_d = sum25_s[24];
        end
    end

    // Stage 2 pipeline register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_mant_q   <= 24'd0;
            totalcarry_q <= 1'b0;
            exp2_q       <= 8'd0;
            sign2_q      <= 1'b0;
        end else begin
            out_mant_q   <= out_mant_d;
            totalcarry_q <= totalcarry_d;
            exp2_q       <= exp2_d;
            sign2_q      <= sign2_d;
        end
    end

    // Stage 3: normalize, detect zero/underflow/overflow, pack the result.
    always_comb begin
        lz_s       = lzc24(out_mant_q);
        norm_s     = out_mant_q << lz_s;
        inc_exp_s  = {1'b0, exp2_q} + 9'd1;
        dec_exp_s  = exp2_q - {3'd0, lz_s};
        sign_d     = 1'b0;
        exponent_d = 8'd0;
        frac_s     = 23'd0;

        if (totalcarry_q) begin
            // Carry out: shift right by one (dropping the LSB) and bump the exponent.
            if (inc_exp_s >= 9'd255) begin
                sign_d     = sign2_q;
                exponent_d = 8'd255;
                frac_s     = 23'd0;
            end else begin
                sign_d     = sign2_q;
                exponent_d = inc_exp_s[7:0];
                frac_s     = out_mant_q[23:1];
            end
        end else if (out_mant_q == 24'd0) begin
            sign_d     = 1'b0;
            exponent_d = 8'd0;
            frac_s     = 23'd0;
        end else if ({3'd0, lz_s} >= exp2_q) begin
            // Normalizing would take the exponent to zero or below: flush to +0.
            sign_d     = 1'b0;
            exponent_d = 8'd0;
            frac_s     = 23'd0;
        end else if (dec_exp_s == 8'd255) begin
            // Only reachable with an exponent-255 input and no shift: saturate.
            sign_d     = sign2_q;
            exponent_d = 8'd255;
            frac_s     = 23'd0;
        end else begin
            sign_d     = sign2_q;
            exponent_d = dec_exp_s;
            frac_s     = norm_s[22:0];
        end

        sum2_d = {sign_d, exponent_d, frac_s};
    end

    // Stage 3 (result) register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q     <= 1'b0;
            exponent_q <= 8'd0;
            sum2_q     <= 32'd0;
        end else begin
            sign_q     <= sign_d;
            exponent_q <= exponent_d;
            sum2_q     <= sum2_d;
        end
    end

    assign bus.res        = res_q;
    assign bus.sss        = sss_q;
    assign bus.mant       = mant_q;
    assign bus.out_mant   = out_mant_q;
    assign bus.totalcarry = totalcarry_q;
    assign bus.sign       = sign_q;
    assign bus.exponent   = exponent_q;
    assign bus.sum2       = sum2_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// ----------------------------------------------------------------------------
// tb_fp_addsub_pipe
// Directed bench for fp_addsub_pipe. Each issued operation pushes its expected
// stage values (hand-derived constants) to a scoreboard queue; after every
// clock the newest entry is checked against stage 1, the one before against
// stage 2, and the oldest is popped and checked against the stage-3 result.
// ----------------------------------------------------------------------------
module tb_fp_addsub_pipe;

    typedef struct {
        string       tag;
        logic        vld;
        logic        dbg;
        logic [7:0]  res;
        logic [23:0] sss;
        logic [23:0] mant;
        logic [23:0] om;
        logic        tc;
        logic [31:0] sum2;
    } exp_t;

    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;
    int   n_fail;
    exp_t sb_q[$];

    fp_addsub_pipe_if bus ();

    fp_addsub_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".res"},        {24'd0, bus.res},        32'd0);
        chk({tag, ".sss"},        {8'd0, bus.sss},         32'd0);
        chk({tag, ".mant"},       {8'd0, bus.mant},        32'd0);
        chk({tag, ".out_mant"},   {8'd0, bus.out_mant},    32'd0);
        chk({tag, ".totalcarry"}, {31'd0, bus.totalcarry}, 32'd0);
        chk({tag, ".sign"},       {31'd0, bus.sign},       32'd0);
        chk({tag, ".exponent"},   {24'd0, bus.exponent},   32'd0);
        chk({tag, ".sum2"},       bus.sum2,                32'd0);
    endtask

    // One clock, then compare every stage against its scoreboard entry.
    task automatic tick();
        int   n;
        exp_t e;
        @(posedge clk);
        #1;
        n = sb_q.size();
        if (n >= 1) begin
            e = sb_q[n-1];
            if (e.dbg) begin
                chk({e.tag, ".res"},  {24'd0, bus.res}, {24'd0, e.res});
                chk({e.tag, ".sss"},  {8'd0, bus.sss},  {8'd0, e.sss});
                chk({e.tag, ".mant"}, {8'd0, bus.mant}, {8'd0, e.mant});
            end
        end
        if (n >= 2) begin
            e = sb_q[n-2];
            if (e.dbg) begin
                chk({e.tag, ".out_mant"},   {8'd0, bus.out_mant},    {8'd0, e.om});
                chk({e.tag, ".totalcarry"}, {31'd0, bus.totalcarry}, {31'd0, e.tc});
            end
        end
        if (n >= 3) begin
            e = sb_q.pop_front();
            if (e.vld) begin
                chk({e.tag, ".sum2"},     bus.sum2,              e.sum2);
                chk({e.tag, ".sign"},     {31'd0, bus.sign},     {31'd0, e.sum2[31]});
                chk({e.tag, ".exponent"}, {24'd0, bus.exponent}, {24'd0, e.sum2[30:23]});
            end
        end
    endtask

    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] want, input logic dbg,
                         input logic [7:0] res, input logic [23:0] sss, input logic [23:0] mant,
                         input logic [23:0] om, input logic tc);
        exp_t e;
        bus.sa     = a[31];
        bus.ea     = a[30:23];
        bus.ma     = a[22:0];
        bus.sb     = b[31];
        bus.eb     = b[30:23];
        bus.mb     = b[22:0];
        bus.opcode = op;
        e.tag  = tag;
        e.vld  = 1'b1;
        e.dbg  = dbg;
        e.res  = res;
        e.sss  = sss;
        e.mant = mant;
        e.om   = om;
        e.tc   = tc;
        e.sum2 = want;
        sb_q.push_back(e);
        tick();
    endtask

    task automatic idle();
        exp_t e;
        bus.sa     = 1'b0;
        bus.ea     = 8'd0;
        bus.ma     = 23'd0;
        bus.sb     = 1'b0;
        bus.eb     = 8'd0;
        bus.mb     = 23'd0;
        bus.opcode = 1'b0;
        e.tag  = "idle";
        e.vld  = 1'b0;
        e.dbg  = 1'b0;
        e.res  = 8'd0;
        e.sss  = 24'd0;
        e.mant = 24'd0;
        e.om   = 24'd0;
        e.tc   = 1'b0;
        e.sum2 = 32'd0;
        sb_q.push_back(e);
        tick();
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        n_fail     = 0;
        rst        = 1'b0;
        bus.sa     = 1'b0;
        bus.sb     = 1'b0;
        bus.opcode = 1'b0;
        bus.ma     = 23'd0;
        bus.mb     = 23'd0;
        bus.ea     = 8'd0;
        bus.eb     = 8'd0;

        // Power-on reset.
        #1 rst = 1'b1;
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Back-to-back: 3+5, 5-3, 3-5 on consecutive cycles.
        issue("add_3p5", 32'h40400000, 32'h40A00000, 1'b0, 32'h41000000, 1'b1,
              8'd1, 24'hA00000, 24'h600000, 24'h000000, 1'b1);
        issue("sub_5m3", 32'h40A00000, 32'h40400000, 1'b1, 32'h40000000, 1'b1,
              8'd1, 24'hA00000, 24'h600000, 24'h400000, 1'b0);
        issue("sub_3m5", 32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 1'b1,
              8'd1, 24'hA00000, 24'h600000, 24'h400000, 1'b0);
        issue("cancel", 32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 1'b1,
              8'd0, 24'hC00000, 24'hC00000, 24'h000000, 1'b0);
        issue("gap30", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 1'b1,
              8'd30, 24'h800000, 24'h000000, 24'h800000, 1'b0);
        issue("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1,
              8'd0, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFE, 1'b1);
        issue("zero_a", 32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 1'b1,
              8'd127, 24'h800000, 24'h000000, 24'h800000, 1'b0);
        issue("uflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b1,
              8'd0, 24'h800001, 24'h800000, 24'h000001, 1'b0);
        issue("frac_cmp", 32'h3FA00000, 32'h3FC00000, 1'b1, 32'hBE800000, 1'b1,
              8'd0, 24'hC00000, 24'hA00000, 24'h200000, 1'b0);
        issue("neg_add", 32'hC0000000, 32'hC0400000, 1'b0, 32'hC0A00000, 1'b1,
              8'd0, 24'hC00000, 24'h800000, 24'h400000, 1'b1);
        idle();
        idle();
        idle();

        // Reset mid-stream discards in-flight work and clears outputs at once.
        issue("pre_rst0", 32'h40400000, 32'h40A00000, 1'b0, 32'h41000000, 1'b0,
              8'd0, 24'd0, 24'd0, 24'd0, 1'b0);
        issue("pre_rst1", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0,
              8'd0, 24'd0, 24'd0, 24'd0, 1'b0);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        sb_q.delete();
        @(posedge clk);
        #1;
        chk_all_zero("hold_rst");
        rst = 1'b0;

        issue("post_a", 32'h40A00000, 32'h40400000, 1'b1, 32'h40000000, 1'b1,
              8'd1, 24'hA00000, 24'h600000, 24'h400000, 1'b0);
        issue("post_b", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b1,
              8'd0, 24'h800000, 24'h800000, 24'h000000, 1'b1);
        issue("post_c", 32'h40400000, 32'h40A00000, 1'b1, 32'hC0000000, 1'b0,
              8'd0, 24'd0, 24'd0, 24'd0, 1'b0);
        idle();
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
